bus_downsizer: RTL and testbench

- Wishbone pipelined bridge from a wide 4*DW-bit slave port (bus master side, e.g. video/memory fabric) to a narrow DW-bit master port (peripheral bus).
- Each accepted wide request is split into 1-4 narrow beats, one per 32-bit lane with nonzero select. Narrow read data is gathered back into one wide acknowledge.
- One wide request is outstanding at a time; narrow beats are pipelined.

---
 rtl/bus_downsizer.sv | 171 +++++++++++++++++
 tb/tb_bus_downsizer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_downsizer.sv
`default_nettype none
// bus_downsizer: splits one 4*DW-bit Wishbone pipelined request into 1-4 DW-bit beats
// (big-endian lanes) and gathers narrow read data into a single wide acknowledge. Rev 1.0
module bus_downsizer #(
  parameter int AW = 24,
  parameter int DW = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_s_cyc,
  input  logic              i_s_stb,
  input  logic              i_s_we,
  input  logic [AW-1:0]     i_s_addr,
  input  logic [4*DW-1:0]   i_s_data,
  input  logic [DW/2-1:0]   i_s_sel,
  output logic              o_s_ack,
  output logic              o_s_stall,
  output logic              o_s_err,
  output logic [4*DW-1:0]   o_s_data,
  output logic              o_m_cyc,
  output logic              o_m_stb,
  output logic              o_m_we,
  output logic [AW+1:0]     o_m_addr,
  output logic [DW-1:0]     o_m_data,
  output logic [DW/8-1:0]   o_m_sel,
  input  logic              i_m_ack,
  input  logic              i_m_stall,
  input  logic              i_m_err,
  input  logic [DW-1:0]     i_m_data
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int         SW     = DW / 8;

  logic [1:0]      state_q, state_d;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [4*DW-1:0] wdata_q;
  logic [DW/2-1:0] sel_q;
  logic [3:0]      iss_mask_q, ack_mask_q;
  logic [2:0]      ack_cnt_q, exp_cnt_q;
  logic [4*DW-1:0] gather_q, sdata_q;
  logic            err_q;

  logic [3:0]      req_mask;
  logic [2:0]      req_cnt;
  logic [1:0]      iss_lane, ack_lane;
  logic            accept, m_stb, last_ack;
  logic [4*DW-1:0] gather_nxt;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign req_mask[k] = |i_s_sel[DW/2-1-k*SW -: SW];
  end

  assign accept   = (state_q == S_IDLE) && i_s_cyc && i_s_stb;
  assign m_stb    = (state_q == S_BUSY) && (iss_mask_q != 4'd0);
  assign last_ack = i_m_ack && ((ack_cnt_q + 3'd1) == exp_cnt_q);

  // Lowest set bit wins: beats go out, and acks come back, in ascending lane order.
  always_comb begin
    req_cnt  = 3'd0;
    iss_lane = 2'd0;
    ack_lane = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      req_cnt = req_cnt + {2'b00, req_mask[k]};
      if (iss_mask_q[k]) iss_lane = 2'(k);
      if (ack_mask_q[k]) ack_lane = 2'(k);
    end
  end

  always_comb begin
    gather_nxt = gather_q;
    for (int k = 0; k < 4; k++) begin
      if (i_m_ack && !we_q && (ack_lane == 2'(k))) gather_nxt[4*DW-1-k*DW -: DW] = i_m_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (req_mask == 4'd0) ? S_RESP : S_BUSY;
      S_BUSY: begin
        if (!i_s_cyc || i_m_err) state_d = S_IDLE;
        else if (last_ack)       state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      iss_mask_q <= 4'd0;
      ack_mask_q <= 4'd0;
      ack_cnt_q  <= 3'd0;
      exp_cnt_q  <= 3'd0;
      gather_q   <= '0;
      sdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          we_q       <= i_s_we;
          addr_q     <= i_s_addr;
          wdata_q    <= i_s_data;
          sel_q      <= i_s_sel;
          iss_mask_q <= req_mask;
          ack_mask_q <= req_mask;
          ack_cnt_q  <= 3'd0;
          exp_cnt_q  <= req_cnt;
          gather_q   <= '0;
          if (req_mask == 4'd0) sdata_q <= '0;
        end
        S_BUSY: begin
          if (!i_s_cyc) begin
            iss_mask_q <= 4'd0;
            ack_mask_q <= 4'd0;
          end else if (i_m_err) begin
            err_q      <= 1'b1;
            iss_mask_q <= 4'd0;
            ack_mask_q <= 4'd0;
          end else begin
            if (m_stb && !i_m_stall) iss_mask_q[iss_lane] <= 1'b0;
            if (i_m_ack) begin
              ack_mask_q[ack_lane] <= 1'b0;
              ack_cnt_q            <= ack_cnt_q + 3'd1;
              gather_q             <= gather_nxt;
              if (last_ack) sdata_q <= gather_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_s_stall = (state_q != S_IDLE);
    o_s_ack   = (state_q == S_RESP);
    o_s_err   = err_q;
    o_s_data  = sdata_q;
    o_m_cyc   = (state_q == S_BUSY);
    o_m_stb   = m_stb;
    o_m_we    = 1'b0;
    o_m_addr  = '0;
    o_m_data  = '0;
    o_m_sel   = '0;
    if (m_stb) begin
      o_m_we   = we_q;
      o_m_addr = {addr_q, iss_lane};
      for (int k = 0; k < 4; k++) begin
        if (iss_lane == 2'(k)) begin
          o_m_data = wdata_q[4*DW-1-k*DW -: DW];
          o_m_sel  = sel_q[DW/2-1-k*SW -: SW];
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bus_downsizer.sv
`default_nettype none
// tb_bus_downsizer: randomized and directed bench with a narrow-bus responder and a
// lane-level reference model of the expected beats and gathered read data.
module tb_bus_downsizer;
  localparam int AW = 24;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic i_reset, i_s_cyc, i_s_stb, i_s_we;
  logic [AW-1:0] i_s_addr;
  logic [127:0]  i_s_data;
  logic [15:0]   i_s_sel;
  logic          o_s_ack, o_s_stall, o_s_err;
  logic [127:0]  o_s_data;
  logic          o_m_cyc, o_m_stb, o_m_we;
  logic [AW+1:0] o_m_addr;
  logic [31:0]   o_m_data;
  logic [3:0]    o_m_sel;
  logic          i_m_ack, i_m_stall, i_m_err;
  logic [31:0]   i_m_data;

  always #5 clk = ~clk;

  bus_downsizer #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_s_cyc(i_s_cyc), .i_s_stb(i_s_stb), .i_s_we(i_s_we), .i_s_addr(i_s_addr),
    .i_s_data(i_s_data), .i_s_sel(i_s_sel),
    .o_s_ack(o_s_ack), .o_s_stall(o_s_stall), .o_s_err(o_s_err), .o_s_data(o_s_data),
    .o_m_cyc(o_m_cyc), .o_m_stb(o_m_stb), .o_m_we(o_m_we), .o_m_addr(o_m_addr),
    .o_m_data(o_m_data), .o_m_sel(o_m_sel),
    .i_m_ack(i_m_ack), .i_m_stall(i_m_stall), .i_m_err(i_m_err), .i_m_data(i_m_data)
  );

  typedef struct packed {
    logic [AW+1:0] a;
    logic [31:0]   d;
    logic [3:0]    s;
    logic          we;
  } beat_t;

  beat_t beats[$];
  beat_t exp_beats[$];
  logic [127:0] exp_data;
  int pass_cnt = 0, total_cnt = 0;
  int stall_beat = -1, stall_left = 0, err_ack = -1, beat_idx = 0, ack_idx = 0;
  bit rand_stall = 0, stable_bad = 0;
  logic [31:0] rd_xor = 32'd0;

  int t_nack, t_nerr, t_first;
  bit t_rcyc, t_cycseen;
  logic [127:0] t_sd;

  function automatic logic [31:0] rd(input logic [AW+1:0] a);
    return (32'hA0 + {30'd0, a[1:0]}) ^ rd_xor;
  endfunction

  function automatic int beat_errs();
    int n = 0;
    if (beats.size() != exp_beats.size()) return 99;
    foreach (beats[i]) if (beats[i] !== exp_beats[i]) n++;
    return n;
  endfunction

  // Narrow slave: acks every accepted beat one cycle later, optional stall/err injection.
  bit r_pend = 0, r_pst = 0;
  logic [AW+1:0] r_pa;
  beat_t r_prev, r_cur;
  initial begin : responder
    i_m_ack = 0; i_m_err = 0; i_m_stall = 0; i_m_data = 0; r_pa = '0; r_prev = '0;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        r_pend = 0; r_pst = 0; i_m_ack = 0; i_m_err = 0; i_m_stall = 0;
        continue;
      end
      i_m_ack  = r_pend;
      i_m_err  = r_pend && (ack_idx == err_ack);
      i_m_data = r_pend ? rd(r_pa) : $urandom;
      if (r_pend) ack_idx++;
      if (o_m_stb && beat_idx == stall_beat && stall_left > 0) begin
        i_m_stall = 1; stall_left--;
      end else begin
        i_m_stall = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      r_cur = {o_m_addr, o_m_data, o_m_sel, o_m_we};
      if (r_pst && o_m_stb && r_cur !== r_prev) stable_bad = 1;
      r_pst  = o_m_stb && i_m_stall;
      r_prev = r_cur;
      r_pend = o_m_stb && !i_m_stall;
      if (r_pend) begin beats.push_back(r_cur); beat_idx++; r_pa = o_m_addr; end
    end
  end

  task automatic build_model(input logic we, input logic [AW-1:0] a, input logic [15:0] s,
                             input logic [127:0] d);
    logic [3:0] ls;
    exp_beats.delete();
    exp_data = '0;
    for (int k = 0; k < 4; k++) begin
      ls = s[15-4*k -: 4];
      if (ls != 4'd0) begin
        exp_beats.push_back({a, 2'(k), d[127-32*k -: 32], ls, we});
        if (!we) exp_data[127-32*k -: 32] = rd({a, 2'(k)});
      end
    end
  endtask

  task automatic clr_resp();
    beats.delete(); beat_idx = 0; ack_idx = 0; stable_bad = 0;
  endtask

  task automatic drive_req(input logic we, input logic [AW-1:0] a, input logic [15:0] s,
                           input logic [127:0] d);
    @(negedge clk);
    i_s_cyc = 1; i_s_stb = 1; i_s_we = we; i_s_addr = a; i_s_sel = s; i_s_data = d;
    @(posedge clk);
  endtask

  task automatic do_txn(input logic we, input logic [AW-1:0] a, input logic [15:0] s,
                        input logic [127:0] d);
    @(posedge clk); #1;
    clr_resp();
    build_model(we, a, s, d);
    drive_req(we, a, s, d);
    t_nack = 0; t_nerr = 0; t_first = 0; t_cycseen = 0; t_rcyc = 0; t_sd = '0;
    for (int c = 1; c <= 60 && t_first == 0; c++) begin
      @(negedge clk);
      if (c == 1) i_s_stb = 0;
      t_cycseen |= o_m_cyc;
      if (o_s_ack || o_s_err) begin
        t_first = c; t_nack += o_s_ack; t_nerr += o_s_err; t_sd = o_s_data; t_rcyc = o_m_cyc;
      end
    end
    i_s_cyc = 0;
    repeat (3) begin @(negedge clk); t_nack += o_s_ack; t_nerr += o_s_err; end
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({o_s_ack, o_s_stall, o_s_err, o_m_cyc, o_m_stb, o_m_we, o_m_sel, o_m_addr, o_m_data, o_s_data} !== '0)
      $display("FAIL reset_outputs: got ack=%b stall=%b err=%b cyc=%b stb=%b sdata=%h, want all 0",
               o_s_ack, o_s_stall, o_s_err, o_m_cyc, o_m_stb, o_s_data);
    else pass_cnt++;
  endtask

  task automatic test_read4();
    do_txn(1'b0, 24'h000010, 16'hFFFF, '0);
    total_cnt++; if (beat_errs() !== 0) $display("FAIL read4_beats: got %0d bad (n=%0d), want 0 (n=4)", beat_errs(), beats.size()); else pass_cnt++;
    total_cnt++; if (t_first !== 6) $display("FAIL read4_latency: got %0d want 6", t_first); else pass_cnt++;
    total_cnt++; if (t_sd !== exp_data) $display("FAIL read4_data: got %h want %h", t_sd, exp_data); else pass_cnt++;
    total_cnt++; if (t_nack !== 1 || t_nerr !== 0) $display("FAIL read4_resp: got ack=%0d err=%0d want 1/0", t_nack, t_nerr); else pass_cnt++;
  endtask

  task automatic test_write2();
    do_txn(1'b1, 24'h0ABCDE, 16'h0F0F,
           {32'hD0D0_0000, 32'hD1D1_1111, 32'hD2D2_2222, 32'hD3D3_3333});
    total_cnt++; if (beat_errs() !== 0) $display("FAIL write2_beats: got %0d bad (n=%0d), want 0 (n=2)", beat_errs(), beats.size()); else pass_cnt++;
    total_cnt++; if (t_first !== 4) $display("FAIL write2_latency: got %0d want 4", t_first); else pass_cnt++;
    total_cnt++; if (t_nack !== 1 || t_nerr !== 0) $display("FAIL write2_resp: got ack=%0d err=%0d want 1/0", t_nack, t_nerr); else pass_cnt++;
  endtask

  task automatic test_write_stall();
    stall_beat = 1; stall_left = 3;
    do_txn(1'b1, 24'h123456, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
    stall_beat = -1;
    total_cnt++; if (stable_bad !== 1'b0) $display("FAIL stall_stable: got changed=%b want 0", stable_bad); else pass_cnt++;
    total_cnt++; if (beat_errs() !== 0) $display("FAIL stall_beats: got %0d bad (n=%0d), want 0 (n=4)", beat_errs(), beats.size()); else pass_cnt++;
    total_cnt++; if (t_first !== 9) $display("FAIL stall_latency: got %0d want 9", t_first); else pass_cnt++;
    total_cnt++; if (t_nack !== 1) $display("FAIL stall_ack: got %0d want 1", t_nack); else pass_cnt++;
  endtask

  task automatic test_error();
    err_ack = 1;
    do_txn(1'b0, 24'h000200, 16'hFFFF, '0);
    err_ack = -1;
    total_cnt++; if (t_nerr !== 1 || t_nack !== 0) $display("FAIL err_resp: got err=%0d ack=%0d want 1/0", t_nerr, t_nack); else pass_cnt++;
    total_cnt++; if (t_first !== 4) $display("FAIL err_latency: got %0d want 4", t_first); else pass_cnt++;
    total_cnt++; if (t_rcyc !== 1'b0) $display("FAIL err_cyc: got %b want 0", t_rcyc); else pass_cnt++;
    rd_xor = 32'h5500_0000;
    do_txn(1'b0, 24'h000300, 16'hFFFF, '0);
    total_cnt++; if (t_sd !== exp_data || t_nack !== 1) $display("FAIL err_followup: got %h ack=%0d want %h ack=1", t_sd, t_nack, exp_data); else pass_cnt++;
  endtask

  task automatic test_abort();
    int n;
    @(posedge clk); #1;
    clr_resp();
    drive_req(1'b0, 24'h000400, 16'hFFFF, '0);
    @(negedge clk); i_s_cyc = 0; i_s_stb = 0;
    @(negedge clk);
    total_cnt++; if (o_m_cyc !== 1'b0) $display("FAIL abort_cyc: got %b want 0", o_m_cyc); else pass_cnt++;
    n = 0;
    repeat (5) begin @(negedge clk); n += o_s_ack + o_s_err; end
    total_cnt++; if (n !== 0) $display("FAIL abort_noresp: got %0d responses want 0", n); else pass_cnt++;
  endtask

  task automatic test_zero_sel();
    do_txn(1'b0, 24'h000500, 16'h0000, {4{32'hFFFF_FFFF}});
    total_cnt++; if (t_first !== 1 || t_nack !== 1) $display("FAIL zero_ack: got cyc#%0d n=%0d want 1/1", t_first, t_nack); else pass_cnt++;
    total_cnt++; if (t_sd !== '0) $display("FAIL zero_data: got %h want 0", t_sd); else pass_cnt++;
    total_cnt++; if (t_cycseen !== 1'b0) $display("FAIL zero_nocyc: got %b want 0", t_cycseen); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    clr_resp();
    stall_beat = 0; stall_left = 50;
    drive_req(1'b0, 24'h000600, 16'hFFFF, '0);
    @(negedge clk); i_s_stb = 0;
    repeat (2) @(negedge clk);
    total_cnt++; if (o_m_cyc !== 1'b1) $display("FAIL arst_busy: got cyc=%b want 1", o_m_cyc); else pass_cnt++;
    #2 i_reset = 1;
    #1;
    stall_left = 0; stall_beat = -1;
    total_cnt++;
    if ({o_s_ack, o_s_stall, o_s_err, o_m_cyc, o_m_stb, o_m_we, o_m_sel, o_m_addr, o_m_data, o_s_data} !== '0)
      $display("FAIL arst_outputs: got stall=%b cyc=%b stb=%b addr=%h sdata=%h want 0",
               o_s_stall, o_m_cyc, o_m_stb, o_m_addr, o_s_data);
    else pass_cnt++;
    @(negedge clk); i_s_cyc = 0;
    @(posedge clk);
    @(negedge clk); i_reset = 0;
    rd_xor = 32'h0077_0000;
    do_txn(1'b0, 24'h000700, 16'hF0F0, '0);
    total_cnt++; if (t_sd !== exp_data || t_nack !== 1) $display("FAIL arst_after: got %h ack=%0d want %h ack=1", t_sd, t_nack, exp_data); else pass_cnt++;
  endtask

  task automatic test_random();
    logic we;
    logic [AW-1:0] a;
    logic [15:0] s;
    logic [127:0] d;
    rand_stall = 1;
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = AW'($urandom);
      d  = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 4; k++)
        s[15-4*k -: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      rd_xor = $urandom;
      do_txn(we, a, s, d);
      total_cnt++; if (beat_errs() !== 0) $display("FAIL rnd_beats[%0d]: got %0d bad (n=%0d) want 0 (n=%0d)", t, beat_errs(), beats.size(), exp_beats.size()); else pass_cnt++;
      total_cnt++; if (t_nack !== 1 || t_nerr !== 0) $display("FAIL rnd_resp[%0d]: got ack=%0d err=%0d want 1/0", t, t_nack, t_nerr); else pass_cnt++;
      if (!we) begin
        total_cnt++; if (t_sd !== exp_data) $display("FAIL rnd_data[%0d]: got %h want %h", t, t_sd, exp_data); else pass_cnt++;
      end
    end
    rand_stall = 0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : main
    i_reset = 1; i_s_cyc = 0; i_s_stb = 0; i_s_we = 0; i_s_addr = '0; i_s_data = '0; i_s_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); i_reset = 0;
    test_read4();
    test_write2();
    test_write_stall();
    test_error();
    test_abort();
    test_zero_sel();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
